// File: rtl/rc_lfsr_gen.sv
// rc_lfsr_gen: sequential Keccak iota round-constant generator.
// Produces RC[ir] for rounds FIRST_ROUND .. FIRST_ROUND+ROUNDS-1 by stepping
// the standard 8-bit rc(t) LFSR once per clock, seven steps per round.
//
// Handshake: outValid=1 means outData/outRoundNumber carry the constant of the
// current round and stay stable until consumed; a cycle with outValid=1 and
// inNext=1 consumes it. inNext is ignored whenever outValid=0. inStart is
// sampled every cycle, aborts whatever is in flight and has priority over inNext.
module rc_lfsr_gen #(
  parameter int LANE_W      = 64,
  parameter int ROUNDS      = 24,
  parameter int FIRST_ROUND = 0
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic              inStart,
  input  logic              inNext,
  output logic              outValid,
  output logic [LANE_W-1:0] outData,
  output logic [7:0]        outRoundNumber,
  output logic              outBusy,
  output logic              outDone,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_GEN   = 2'd2,
    ST_READY = 2'd3
  } state_t;

  // Skipped rounds still cost seven LFSR steps each.
  localparam int SKIP_STEPS = 7 * FIRST_ROUND;
  localparam int SKIP_W     = (SKIP_STEPS > 1) ? $clog2(SKIP_STEPS) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST =
    SKIP_W'((SKIP_STEPS > 0) ? SKIP_STEPS - 1 : 0);

  // Round index k runs 0 .. ROUNDS-1 within a run.
  localparam int K_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(ROUNDS - 1);

  // outRoundNumber is 1-based and absolute: FIRST_ROUND + k + 1.
  localparam logic [7:0] RN_BASE = 8'(FIRST_ROUND + 1);

  localparam state_t     START_ST  = (FIRST_ROUND > 0) ? ST_SKIP : ST_GEN;
  localparam logic [7:0] LFSR_INIT = 8'h01;
  // x^8+x^6+x^5+x^4+1 with R[0] the oldest bit: feedback lands on bits 0,4,5,6.
  localparam logic [7:0] LFSR_TAPS = 8'b0111_0001;

  state_t              state;
  state_t              state_next;
  logic [7:0]          lfsr;
  logic [7:0]          lfsr_step;
  logic [2:0]          step_cnt;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [K_W-1:0]      k;
  logic [LANE_W-1:0]   shadow;
  logic [LANE_W-1:0]   shadow_ins;
  logic [7:0]          rnum_next;

  // Control strobes decoded by the FSM for the datapath.
  logic load;      // restart the run from the beginning
  logic step_en;   // advance the LFSR by one step
  logic gen_done;  // seventh step of a GEN round: publish the constant
  logic adv;       // constant consumed, more rounds to go
  logic fin;       // last constant consumed

  // One LFSR step: output bit is R[0], shift up, fold R[7] back in.
  assign lfsr_step = {lfsr[6:0], 1'b0} ^ (lfsr[7] ? LFSR_TAPS : 8'h00);

  // Shadow with the current output bit merged in. Only bit positions
  // 2^j-1 are ever written; step j owns position 2^j-1. Positions beyond the
  // lane simply do not exist, so those steps are taken and their bit dropped.
  for (genvar i = 0; i < LANE_W; i++) begin : g_shadow
    if (((i + 1) & i) == 0) begin : g_tap
      assign shadow_ins[i] = shadow[i] | (lfsr[0] & (step_cnt == 3'($clog2(i + 1))));
    end else begin : g_pass
      assign shadow_ins[i] = shadow[i];
    end
  end

  assign rnum_next = RN_BASE + 8'(k);

  // State register.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes; inStart overrides everything else.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step_en    = 1'b0;
    gen_done   = 1'b0;
    adv        = 1'b0;
    fin        = 1'b0;
    if (inStart) begin
      load       = 1'b1;
      state_next = START_ST;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          step_en = 1'b1;
          if (skip_cnt == SKIP_LAST) begin
            state_next = ST_GEN;
          end
        end
        ST_GEN: begin
          step_en = 1'b1;
          if (step_cnt == 3'd6) begin
            gen_done   = 1'b1;
            state_next = ST_READY;
          end
        end
        ST_READY: begin
          if (inNext) begin
            if (k == K_LAST) begin
              fin        = 1'b1;
              state_next = ST_IDLE;
            end else begin
              adv        = 1'b1;
              state_next = ST_GEN;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // LFSR, step/skip/round counters and the shadow lane.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      lfsr     <= LFSR_INIT;
      step_cnt <= 3'd0;
      skip_cnt <= '0;
      k        <= '0;
      shadow   <= '0;
    end else if (load) begin
      lfsr     <= LFSR_INIT;
      step_cnt <= 3'd0;
      skip_cnt <= '0;
      k        <= '0;
      shadow   <= '0;
    end else begin
      if (step_en) begin
        lfsr <= lfsr_step;
      end
      // Skip counter stops at its last value rather than wrapping.
      if (state == ST_SKIP && skip_cnt != SKIP_LAST) begin
        skip_cnt <= skip_cnt + 1'b1;
      end
      if (state == ST_GEN) begin
        shadow   <= shadow_ins;
        step_cnt <= gen_done ? 3'd0 : step_cnt + 3'd1;
      end
      // The next round starts from an empty shadow; the LFSR keeps running.
      if (adv) begin
        shadow <= '0;
        k      <= k + 1'b1;
      end
    end
  end

  // Published constant, round number and the done pulse.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      outData        <= '0;
      outRoundNumber <= 8'd0;
      outDone        <= 1'b0;
    end else begin
      outDone <= fin;
      if (gen_done) begin
        outData        <= shadow_ins;
        outRoundNumber <= rnum_next;
      end
    end
  end

  assign outValid = (state == ST_READY);
  assign outBusy  = (state == ST_SKIP) || (state == ST_GEN);
  assign dbgState = state;

endmodule

// File: tb/tb_rc_lfsr_gen.sv
// Bench for rc_lfsr_gen: three parameterisations driven one at a time,
// compared against a reference built from the rc(t) definition.
module tb_rc_lfsr_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] start_r;
  logic [2:0] next_r;

  logic        valid0, valid1, valid2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [63:0] data0, data2;
  logic [31:0] data1;
  logic [7:0]  rnum0, rnum1, rnum2;
  logic [1:0]  st0, st1, st2;

  logic [2:0]       valid_a, busy_a, done_a;
  logic [2:0][63:0] data_a;
  logic [2:0][7:0]  rnum_a;

  always_comb begin
    valid_a   = {valid2, valid1, valid0};
    busy_a    = {busy2, busy1, busy0};
    done_a    = {done2, done1, done0};
    data_a[0] = data0;
    data_a[1] = {32'd0, data1};
    data_a[2] = data2;
    rnum_a[0] = rnum0;
    rnum_a[1] = rnum1;
    rnum_a[2] = rnum2;
  end

  rc_lfsr_gen #(.LANE_W(64), .ROUNDS(24), .FIRST_ROUND(0)) u_def (
    .inClk(clk), .inRstN(rst_n), .inStart(start_r[0]), .inNext(next_r[0]),
    .outValid(valid0), .outData(data0), .outRoundNumber(rnum0),
    .outBusy(busy0), .outDone(done0), .dbgState(st0)
  );

  rc_lfsr_gen #(.LANE_W(32), .ROUNDS(22), .FIRST_ROUND(0)) u_w32 (
    .inClk(clk), .inRstN(rst_n), .inStart(start_r[1]), .inNext(next_r[1]),
    .outValid(valid1), .outData(data1), .outRoundNumber(rnum1),
    .outBusy(busy1), .outDone(done1), .dbgState(st1)
  );

  rc_lfsr_gen #(.LANE_W(64), .ROUNDS(12), .FIRST_ROUND(12)) u_skip (
    .inClk(clk), .inRstN(rst_n), .inStart(start_r[2]), .inNext(next_r[2]),
    .outValid(valid2), .outData(data2), .outRoundNumber(rnum2),
    .outBusy(busy2), .outDone(done2), .dbgState(st2)
  );

  function automatic int p_lane(input int i);
    return (i == 1) ? 32 : 64;
  endfunction
  function automatic int p_rounds(input int i);
    return (i == 0) ? 24 : ((i == 1) ? 22 : 12);
  endfunction
  function automatic int p_first(input int i);
    return (i == 2) ? 12 : 0;
  endfunction

  // ---------------- reference model ----------------
  // rc(t) straight from its definition: R = 1000_0000, then t mod 255 times
  // R = 0||R, XOR R[8] into R[0],R[4],R[5],R[6], truncate to 8 bits.
  function automatic bit rc_bit(input int t);
    bit r [0:8];
    int n;
    n = t % 255;
    for (int i = 0; i < 9; i++) r[i] = 1'b0;
    r[0] = 1'b1;
    for (int s = 0; s < n; s++) begin
      for (int i = 8; i > 0; i--) r[i] = r[i-1];
      r[0] = 1'b0;
      r[0] = r[0] ^ r[8];
      r[4] = r[4] ^ r[8];
      r[5] = r[5] ^ r[8];
      r[6] = r[6] ^ r[8];
    end
    return r[0];
  endfunction

  // RC[ir][2^j-1] = rc(j + 7*ir) for every position inside the lane.
  function automatic logic [63:0] rc_const(input int ir, input int lane);
    logic [63:0] v;
    int pos;
    v = '0;
    for (int j = 0; j < 7; j++) begin
      pos = (1 << j) - 1;
      if (pos < lane) v[pos] = rc_bit(j + 7 * ir);
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] obs [3][24];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int inst, input int budget, output int cyc);
    cyc = 0;
    while (!valid_a[inst] && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_start(input int inst, input bit with_next);
    start_r[inst] = 1'b1;
    next_r[inst]  = with_next;
    @(negedge clk);
    start_r[inst] = 1'b0;
    next_r[inst]  = 1'b0;
  endtask

  // Full run on one instance. held=1 keeps inNext high for the whole run;
  // held=0 waits a random number of cycles per constant and throws random
  // inNext pulses at the generator while it is not valid.
  task automatic run_check(input int inst, input bit held);
    int c, exp_c, gap, rounds, first, lane, done_c;
    logic [63:0] exp_q[$];
    logic [63:0] cur;
    rounds = p_rounds(inst);
    first  = p_first(inst);
    lane   = p_lane(inst);
    cur    = '0;
    for (int r = 0; r < rounds; r++) exp_q.push_back(rc_const(first + r, lane));
    start_r[inst] = 1'b1;
    next_r[inst]  = held;
    @(negedge clk);
    start_r[inst] = 1'b0;
    c      = 0;
    done_c = -1;
    exp_c  = 7 * (first + 1);
    for (int k = 0; k < rounds; k++) begin
      while (!valid_a[inst] && c < exp_c + 4) begin
        if (!held) next_r[inst] = 1'($urandom_range(0, 1));
        @(negedge clk);
        c++;
      end
      if (!held) next_r[inst] = 1'b0;
      check($sformatf("i%0d_r%0d_lat", inst, k + 1), 64'(c), 64'(exp_c));
      cur = exp_q.pop_front();
      check($sformatf("i%0d_r%0d_data", inst, k + 1), data_a[inst], cur);
      check($sformatf("i%0d_r%0d_rnum", inst, k + 1), 64'(rnum_a[inst]), 64'(first + k + 1));
      check($sformatf("i%0d_r%0d_busy", inst, k + 1), 64'(busy_a[inst]), 64'd0);
      obs[inst][k] = data_a[inst];
      if (!held) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          @(negedge clk);
          c++;
        end
        check($sformatf("i%0d_r%0d_hold", inst, k + 1),
              {data_a[inst][62:0], valid_a[inst]}, {cur[62:0], 1'b1});
      end
      next_r[inst] = 1'b1;
      @(negedge clk);
      c++;
      if (!held) next_r[inst] = 1'b0;
      if (k == rounds - 1) begin
        check($sformatf("i%0d_done", inst), 64'(done_a[inst]), 64'd1);
        done_c = c;
      end else begin
        check($sformatf("i%0d_r%0d_vdrop", inst, k + 1), 64'(valid_a[inst]), 64'd0);
        check($sformatf("i%0d_r%0d_busy1", inst, k + 1), 64'(busy_a[inst]), 64'd1);
        check($sformatf("i%0d_r%0d_nodone", inst, k + 1), 64'(done_a[inst]), 64'd0);
      end
      exp_c = c + 7;
    end
    next_r[inst] = 1'b0;
    if (held) begin
      check($sformatf("i%0d_runlen", inst), 64'(done_c),
            64'(7 * (first + 1) + 7 * (rounds - 1) + rounds));
    end
    @(negedge clk);
    check($sformatf("i%0d_done_pulse", inst), 64'(done_a[inst]), 64'd0);
    check($sformatf("i%0d_idle_valid", inst), 64'(valid_a[inst]), 64'd0);
    check($sformatf("i%0d_idle_data", inst), data_a[inst], cur);
    check($sformatf("i%0d_idle_rnum", inst), 64'(rnum_a[inst]), 64'(first + rounds));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    bit stable;
    rst_n   = 1'b0;
    start_r = '0;
    next_r  = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid%0d", i), 64'(valid_a[i]), 64'd0);
      check($sformatf("rst_data%0d", i), data_a[i], 64'd0);
      check($sformatf("rst_rnum%0d", i), 64'(rnum_a[i]), 64'd0);
      check($sformatf("rst_busy%0d", i), 64'(busy_a[i]), 64'd0);
      check($sformatf("rst_done%0d", i), 64'(done_a[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Default parameters, inNext held high throughout.
    run_check(0, 1'b1);

    // Abort during round 5 GEN: restart must come back with round 1.
    pulse_start(0, 1'b0);
    for (int r = 1; r <= 4; r++) begin
      wait_valid(0, 20, c);
      next_r[0] = 1'b1;
      @(negedge clk);
      next_r[0] = 1'b0;
    end
    @(negedge clk);
    check("abort_pre_busy", 64'(busy_a[0]), 64'd1);
    pulse_start(0, 1'b0);
    check("abort_vlow", 64'(valid_a[0]), 64'd0);
    wait_valid(0, 20, c);
    check("abort_lat", 64'(c), 64'd7);
    check("abort_data", data_a[0], 64'h1);
    check("abort_rnum", 64'(rnum_a[0]), 64'd1);
    check("abort_nodone", 64'(done_a[0]), 64'd0);

    // inStart together with inNext in READY of round 2: restart wins.
    next_r[0] = 1'b1;
    @(negedge clk);
    next_r[0] = 1'b0;
    wait_valid(0, 20, c);
    check("sim_r2_rnum", 64'(rnum_a[0]), 64'd2);
    check("sim_r2_data", data_a[0], 64'h8082);
    pulse_start(0, 1'b1);
    check("sim_vlow", 64'(valid_a[0]), 64'd0);
    wait_valid(0, 20, c);
    check("sim_lat", 64'(c), 64'd7);
    check("sim_rnum", 64'(rnum_a[0]), 64'd1);
    check("sim_data", data_a[0], 64'h1);

    // No inNext for 100 cycles: constant stays put.
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!(valid_a[0] && data_a[0] == 64'h1 && rnum_a[0] == 8'd1 && !busy_a[0]))
        stable = 1'b0;
    end
    check("stable_100", 64'(stable), 64'd1);

    // Asynchronous reset in the middle of round 2 GEN.
    next_r[0] = 1'b1;
    @(negedge clk);
    next_r[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_pre_busy", 64'(busy_a[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(valid_a[0]), 64'd0);
    check("arst_data", data_a[0], 64'd0);
    check("arst_rnum", 64'(rnum_a[0]), 64'd0);
    check("arst_busy", 64'(busy_a[0]), 64'd0);
    check("arst_done", 64'(done_a[0]), 64'd0);
    @(negedge clk);
    check("arst_done2", 64'(done_a[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(0, 1'b0);
    wait_valid(0, 20, c);
    check("arst_restart_lat", 64'(c), 64'd7);
    check("arst_restart_data", data_a[0], 64'h1);

    // Randomized consumption on all parameterisations, plus held runs.
    run_check(0, 1'b0);
    run_check(1, 1'b0);
    run_check(1, 1'b1);
    run_check(2, 1'b1);
    run_check(2, 1'b0);

    // Published FIPS 202 values at the boundary rounds.
    check("def_r1", obs[0][0], 64'h0000000000000001);
    check("def_r2", obs[0][1], 64'h0000000000008082);
    check("def_r3", obs[0][2], 64'h800000000000808A);
    check("def_r24", obs[0][23], 64'h8000000080008008);
    check("w32_r3", obs[1][2], 64'h000000000000808A);
    check("w32_r22", obs[1][21], 64'h0000000000008080);
    check("skip_r13", obs[2][0], 64'h000000008000808B);
    check("skip_r24", obs[2][11], 64'h8000000080008008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
